// File: rtl/gpio_input_port.sv
// gpio_input_port
//   Memory-mapped single-pin GPIO input peripheral. Synchronises an external
//   pin, optionally debounces it, latches rising/falling edges into sticky
//   write-1-to-clear status flags and raises a level interrupt for enabled
//   flags.
//
//   Register map (full 32-bit address compare, anything else reads 0):
//     BASE_ADDR+0  DATA    RO  {30'b0, sync1, level}
//     BASE_ADDR+4  STATUS  W1C {30'b0, fall, rise}
//     BASE_ADDR+8  CTRL    RW  {30'b0, fall_ie, rise_ie}
//
//   Build option: define GPIO_IN_DEBOUNCE_EN to insert the debounce counter
//   (DEBOUNCE_CYCLES / CNT_W take effect). Without it, level follows the
//   synchronised pin every cycle.
//
//   Ports:
//     CLK     clock
//     reset   asynchronous, active-high reset
//     WE      write enable from memory stage
//     A       memory-mapped address
//     WD      write data
//     pin_in  asynchronous external pin
//     RD      registered read data (1-cycle latency)
//     irq     level interrupt, active-high, decoded from registers only
module gpio_input_port #(
   parameter logic [31:0] BASE_ADDR       = 32'h8000_0010,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        WE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic        pin_in,
   output logic [31:0] RD,
   output logic        irq
);

   localparam logic [31:0] ADDR_DATA   = BASE_ADDR;
   localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd4;
   localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'd8;

   // Reject configurations the debounce counter cannot represent.
   if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 ||
       (CNT_W < 32 && (64'(DEBOUNCE_CYCLES - 1) >> CNT_W) != 64'd0)) begin : g_param_check
      $error("gpio_input_port: DEBOUNCE_CYCLES must be >= 1 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
   end

   logic        sync0;
   logic        sync1;
   logic        level;
   logic        level_nxt;
   logic        rise;
   logic        fall;
   logic        rise_ie;
   logic        fall_ie;
   logic        rise_set;
   logic        fall_set;
   logic        sel_data;
   logic        sel_status;
   logic        sel_ctrl;
   logic        wr_status;
   logic        wr_ctrl;
   logic [31:0] rd_nxt;

   // Only WD[1:0] carry register content.
   logic        unused_wd_hi;
   assign unused_wd_hi = ^WD[31:2];

   // ------------------------------------------------------------------
   // Two-flop synchroniser; sync1 is the only pin-derived signal used.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
      end else begin
         sync0 <= pin_in;
         sync1 <= sync0;
      end
   end

   // ------------------------------------------------------------------
   // Accepted level: debounced or straight from the synchroniser.
   // ------------------------------------------------------------------
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // A sample that returns to the current level restarts the count, so only
   // DEBOUNCE_CYCLES consecutive differing samples change the level.
   always_comb begin
      level_nxt = level;
      cnt_nxt   = cnt;
      if (sync1 == level) begin
         cnt_nxt = '0;
      end else if (cnt == CNT_LAST) begin
         level_nxt = sync1;
         cnt_nxt   = '0;
      end else begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end
`else
   assign level_nxt = sync1;
`endif

   // Edge detection on the level transition itself, so the flag sets on the
   // same edge the level changes.
   assign rise_set = level_nxt & ~level;
   assign fall_set = ~level_nxt & level;

   // ------------------------------------------------------------------
   // Bus decode and read mux (pre-write register values).
   // ------------------------------------------------------------------
   assign sel_data   = (A == ADDR_DATA);
   assign sel_status = (A == ADDR_STATUS);
   assign sel_ctrl   = (A == ADDR_CTRL);
   assign wr_status  = WE & sel_status;
   assign wr_ctrl    = WE & sel_ctrl;

   always_comb begin
      rd_nxt = '0;
      if (sel_data) begin
         rd_nxt[1:0] = {sync1, level};
      end else if (sel_status) begin
         rd_nxt[1:0] = {fall, rise};
      end else if (sel_ctrl) begin
         rd_nxt[1:0] = {fall_ie, rise_ie};
      end
   end

   // ------------------------------------------------------------------
   // Level, sticky flags, control and registered read data.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         level   <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         rise_ie <= 1'b0;
         fall_ie <= 1'b0;
         RD      <= '0;
      end else begin
         level <= level_nxt;
         // A new edge on the same cycle as a W1C keeps the flag set.
         rise  <= rise_set | (rise & ~(wr_status & WD[0]));
         fall  <= fall_set | (fall & ~(wr_status & WD[1]));
         if (wr_ctrl) begin
            rise_ie <= WD[0];
            fall_ie <= WD[1];
         end
         RD <= rd_nxt;
      end
   end

   // Decoded from flops only, so it cannot glitch.
   assign irq = (rise & rise_ie) | (fall & fall_ie);

endmodule

// File: tb/tb_gpio_input_port.sv
`timescale 1ns/1ps
module tb_gpio_input_port;

   localparam logic [31:0] BASE = 32'h8000_0010;
   localparam int unsigned DEB  = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam bit          DEB_ON = 1'b1;
   localparam int unsigned LAT    = DEB + 2;
`else
   localparam bit          DEB_ON = 1'b0;
   localparam int unsigned LAT    = 3;
`endif

   logic        CLK = 1'b0;
   logic        reset;
   logic        WE;
   logic [31:0] A;
   logic [31:0] WD;
   logic        pin_in;
   logic [31:0] RD;
   logic        irq;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   gpio_input_port #(
      .BASE_ADDR      (BASE),
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (16)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .WE    (WE),
      .A     (A),
      .WD    (WD),
      .pin_in(pin_in),
      .RD    (RD),
      .irq   (irq)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: pin history, window of recent synchronised samples.
   // The level changes once the last DEB synchronised samples all agree
   // and differ from the current level.
   // ------------------------------------------------------------------
   bit          pin_q[$];   // [0] = pin one edge ago, [1] = two edges ago
   bit          sync_q[$];  // previous DEB-1 synchronised samples
   logic        m_level = 1'b0;
   logic        m_rise  = 1'b0;
   logic        m_fall  = 1'b0;
   logic [1:0]  m_ie    = 2'b00;
   logic [31:0] m_rd    = '0;
   logic        m_irq;

   assign m_irq = (m_rise & m_ie[0]) | (m_fall & m_ie[1]);

   function automatic bit f_sync1();
      return (pin_q.size() >= 2) ? pin_q[1] : 1'b0;
   endfunction

   function automatic bit f_next_level(input bit s1);
      if (!DEB_ON) return s1;
      if (sync_q.size() < DEB - 1) return m_level;
      foreach (sync_q[i]) if (sync_q[i] != s1) return m_level;
      return s1;
   endfunction

   function automatic logic [31:0] f_read(input logic [31:0] a);
      if (a == BASE)       return {30'b0, f_sync1(), m_level};
      if (a == BASE + 4)   return {30'b0, m_fall, m_rise};
      if (a == BASE + 8)   return {30'b0, m_ie};
      return 32'h0;
   endfunction

   function automatic bit f_flag(input bit cur, input bit set, input bit clr);
      if (set) return 1'b1;
      if (clr) return 1'b0;
      return cur;
   endfunction

   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         pin_q.delete();
         sync_q.delete();
         m_level <= 1'b0;
         m_rise  <= 1'b0;
         m_fall  <= 1'b0;
         m_ie    <= 2'b00;
         m_rd    <= '0;
      end else begin
         m_rd    <= f_read(A);
         m_level <= f_next_level(f_sync1());
         m_rise  <= f_flag(m_rise, f_next_level(f_sync1()) && !m_level,
                           WE && A == BASE + 4 && WD[0]);
         m_fall  <= f_flag(m_fall, !f_next_level(f_sync1()) && m_level,
                           WE && A == BASE + 4 && WD[1]);
         if (WE && A == BASE + 8) m_ie <= WD[1:0];
         sync_q.push_back(f_sync1());
         if (sync_q.size() > DEB - 1) void'(sync_q.pop_front());
         pin_q.push_front(pin_in);
         if (pin_q.size() > 2) void'(pin_q.pop_back());
      end
   end

   // Continuous comparison against the model on the inactive edge.
   always @(negedge CLK) begin
      chk("model_rd", RD, m_rd);
      chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
   end

   // ------------------------------------------------------------------
   // Bus helpers (inputs change on the falling edge).
   // ------------------------------------------------------------------
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge CLK);
      A = addr; WD = data; WE = 1'b1;
      @(negedge CLK);
      WE = 1'b0; A = 32'h0; WD = 32'h0;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] val);
      @(negedge CLK);
      A = addr; WE = 1'b0;
      @(posedge CLK);
      #1 val = RD;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2 reset = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge CLK);
   endtask

   logic [31:0] v;
   int          n;
   logic [31:0] addrs [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; WE = 1'b0; A = '0; WD = '0; pin_in = 1'b0;
      repeat (2) @(negedge CLK);
      reset = 1'b0;

      // Reset state
      rd(BASE, v);          chk("reset_data", v, 32'h0);
      rd(BASE + 4, v);      chk("reset_status", v, 32'h0);
      rd(BASE + 8, v);      chk("reset_ctrl", v, 32'h0);
      rd(32'h8000_0020, v); chk("unmapped_read", v, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);

      // Rise latency and W1C
      wr(BASE + 8, 32'hFFFF_FFFF);
      rd(BASE + 8, v);      chk("ctrl_readback", v, 32'h3);
      @(negedge CLK);
      pin_in = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         #1;
         if (irq) begin n = i; break; end
      end
      chk("rise_latency", n, LAT);
      rd(BASE + 4, v);      chk("status_after_rise", v, 32'h1);
      rd(BASE, v);          chk("data_high", v, 32'h3);
      wr(BASE + 4, 32'h1);
      chk("irq_after_w1c", {31'b0, irq}, 32'h0);
      rd(BASE + 4, v);      chk("status_after_w1c", v, 32'h0);

      // Short pulse: filtered with debounce, captured without
      pin_in = 1'b0;
      do_reset();
      hold(4);
      pin_in = 1'b1;
      hold(3);
      pin_in = 1'b0;
      hold(12);
      rd(BASE + 4, v);      chk("glitch_status", v, DEB_ON ? 32'h0 : 32'h3);
      rd(BASE, v);          chk("glitch_data", v, 32'h0);

      // Fall-only interrupt
      wr(BASE + 4, 32'h3);
      wr(BASE + 8, 32'h2);
      pin_in = 1'b1;
      hold(10);
      chk("irq_after_rise_fall_ie", {31'b0, irq}, 32'h0);
      rd(BASE + 4, v);      chk("status_rise_only", v, 32'h1);
      pin_in = 1'b0;
      hold(10);
      chk("irq_after_fall", {31'b0, irq}, 32'h1);
      rd(BASE + 4, v);      chk("status_both", v, 32'h3);
      wr(BASE + 4, 32'h2);
      chk("irq_after_fall_clear", {31'b0, irq}, 32'h0);
      rd(BASE + 4, v);      chk("status_rise_left", v, 32'h1);

      // W1C on the exact edge a rise is detected: set wins
      wr(BASE + 4, 32'h3);
      @(negedge CLK);
      pin_in = 1'b1;
      repeat (LAT - 1) @(negedge CLK);
      A = BASE + 4; WD = 32'h1; WE = 1'b1;
      @(negedge CLK);
      WE = 1'b0; WD = '0;
      rd(BASE + 4, v);      chk("set_wins_over_clear", v, 32'h1);

      // Reset in the middle of a debounce
      wr(BASE + 8, 32'h1);
      pin_in = 1'b0;
      hold(12);
      @(negedge CLK);
      A = BASE + 4;
      pin_in = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      #1 chk("pre_reset_irq", {31'b0, irq}, 32'h1);
      chk("pre_reset_rd", RD, 32'h3);
      @(negedge CLK);
      #2 reset = 1'b1;
      #1 chk("async_reset_rd", RD, 32'h0);
      chk("async_reset_irq", {31'b0, irq}, 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      repeat (LAT) @(posedge CLK);
      #1 chk("post_reset_not_yet", RD, 32'h0);
      @(posedge CLK);
      #1 chk("post_reset_rise", RD, 32'h1);

      // Randomised traffic against the model
      addrs[0] = BASE;       addrs[1] = BASE + 4;  addrs[2] = BASE + 8;
      addrs[3] = BASE + 12;  addrs[4] = BASE + 2;  addrs[5] = 32'h8000_0020;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if ($urandom_range(0, 9) == 0) pin_in = ~pin_in;
         if ($urandom_range(0, 49) == 0) pin_in = ~pin_in;
         A  = addrs[$urandom_range(0, 5)];
         WE = ($urandom_range(0, 3) == 0);
         WD = $urandom;
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b1;
            @(negedge CLK);
            reset = 1'b0;
         end
      end
      @(negedge CLK);
      WE = 1'b0;
      @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
